ft_cmd_decoder: RTL and testbench
=================================

# ft_cmd_decoder

Byte-level command parser between the FT245 synchronous-FIFO receiver and the controller core. It consumes one received byte per `rx_valid` strobe, assembles multi-byte commands (opcode plus 0–2 argument bytes) and emits single-cycle action strobes with latched arguments. These strobes drive the register file (TEC PWM, CCD readout mode), the AD9826 serial configurator, the MCP3008 poll, the shutter and the CCD readout sequencer. Incomplete commands are abandoned after a timeout so that a lost byte cannot desynchronise the host link.

## Interface
- `CMD_SET_REGISTER`, 8'h01, opcode; 2 args: address byte, value byte
- `CMD_RW_ADCONF`, 8'h02, opcode; 2 args: AD9826 word high byte, low byte
- `CMD_TOGGLE_MCP`, 8'h03, opcode; no args
- `CMD_OPEN_SHUTTER`, 8'h04, opcode; no args
- `CMD_CLOSE_SHUTTER`, 8'h05, opcode; no args
- `CMD_TOGGLE_READ_CCD`, 8'h06, opcode; no args
- `TIMEOUT_CYCLES`, 10000, maximum number of idle cycles allowed between argument bytes; must be ≥ 2
- `clk`  in  1  system clock; all logic is on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high
- `rx_valid`  in  1  one-cycle strobe, one per byte; may be asserted on back-to-back cycles
- `adconf_busy`  in  1  high while the AD9826 serial configurator is executing a transfer
- `reg_wr`  out  1  one-cycle register-write strobe
- `reg_addr`  out  2  register address (arg1[1:0]); held until the next write
- `reg_data`  out  8  register value (arg2); held until the next write
- `adconf_start`  out  1  one-cycle strobe that starts an AD9826 transfer
- `adconf_word`  out  16  {arg1, arg2}; held until the next accepted transfer
- `mcp_toggle`, `shutter_open`, `shutter_close`, `ccd_toggle`  out  1 each  one-cycle action strobes
- `busy`  out  1  high while a command is partially received
- `err`  out  1  one-cycle strobe on unknown opcode, timeout, or AD9826 command rejected
- `err_code`  out  2  cause of the last `err`: 1 = unknown opcode, 2 = timeout, 3 = adconf busy; held until the next `err`

## Operation
- State machine with states IDLE, ARG1, ARG2. A latched `opcode` register holds the current command.
- IDLE:
  - On `rx_valid` with an opcode that takes no arguments, pulse the matching strobe; stay in IDLE.
  - On `rx_valid` with `CMD_SET_REGISTER` or `CMD_RW_ADCONF`, latch the opcode and go to ARG1.
  - On `rx_valid` with any other byte, pulse `err` with `err_code`=1; stay in IDLE.
- ARG1: on `rx_valid`, latch `arg1` and go to ARG2.
- ARG2: on `rx_valid`, go to IDLE and execute the command:
  - SET_REGISTER: load `reg_addr`←arg1[1:0] and `reg_data`←byte, and pulse `reg_wr`. arg1[7:2] is ignored.
  - RW_ADCONF with `adconf_busy`=0: load `adconf_word` and pulse `adconf_start`.
  - RW_ADCONF with `adconf_busy`=1: drop the command and pulse `err` with `err_code`=2'd3. `adconf_word` is unchanged.
- Timeout: a counter clears on entry to ARG1, on every `rx_valid`, and in IDLE, and increments every cycle in ARG1/ARG2. When it reaches `TIMEOUT_CYCLES`-1 with no `rx_valid` in that cycle, go to IDLE and pulse `err` with `err_code`=2. A byte arriving in that same cycle is accepted and no timeout occurs.
- Argument bytes are never interpreted as opcodes. An argument byte equal to an opcode value is plain data.
- `busy` = (state ≠ IDLE).
- At most one action strobe or `err` is high in any cycle.
- Reset: IDLE; all strobes 0; `busy` 0; `reg_addr` 0, `reg_data` 0, `adconf_word` 0, `err_code` 0; counter 0. Reset mid-command discards the partial command and emits no strobe.

## Timing
- All outputs are registered.
- A strobe is high in the cycle after the rising edge that samples the final byte of its command: 1-cycle latency.
- `reg_addr`/`reg_data`/`adconf_word` change in the same cycle their strobe rises, and are stable while it is high.
- Back-to-back `rx_valid` is fully supported with no dead cycle. A new opcode may arrive in the cycle right after the last argument byte.
- `adconf_busy` is sampled in the cycle the final RW_ADCONF byte arrives.
- `rst` has priority over `rx_valid`.

## Test plan
- Reset, then bytes 01,02,00 at one per cycle → one `reg_wr` cycle with `reg_addr`=2, `reg_data`=00; then byte 06 → `ccd_toggle` one cycle; `busy` is high for exactly 2 cycles.
- Bytes 02,80,FF with `adconf_busy`=0 → `adconf_start` with `adconf_word`=16'h80FF. Repeat with `adconf_busy`=1 → no start; `err`, `err_code`=3; word stays 80FF.
- Bytes 04, 05, 03 at 5-cycle spacing → `shutter_open`, `shutter_close`, `mcp_toggle` one cycle each, in order.
- Byte 7E in IDLE → `err`, `err_code`=1. Then bytes 01,06,06 → `reg_wr` with addr 2, data 06, and no `ccd_toggle`.
- `TIMEOUT_CYCLES`=16: byte 01, then silence → `err` with `err_code`=2 exactly 16 cycles after entering ARG1, `busy` falls. A following byte 04 → `shutter_open`.
- Byte 02, then `rst` for 1 cycle, then bytes 11,22 → no strobes; `err` with `err_code`=1 for byte 11; byte 22 gives another unknown-opcode `err`.

Source files
------------

// File: rtl/ft_cmd_decoder.sv
// Byte-stream command parser: opcode plus 0-2 argument bytes, emits one-cycle action strobes.
// Latency 1 cycle from final byte; rx_valid is never back-pressured, stalled commands time out.
module ft_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        adconf_busy,
  output logic        reg_wr,
  output logic [1:0]  reg_addr,
  output logic [7:0]  reg_data,
  output logic        adconf_start,
  output logic [15:0] adconf_word,
  output logic        mcp_toggle,
  output logic        shutter_open,
  output logic        shutter_close,
  output logic        ccd_toggle,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [7:0] CMD_SET_REGISTER    = 8'h01;
  localparam logic [7:0] CMD_RW_ADCONF       = 8'h02;
  localparam logic [7:0] CMD_TOGGLE_MCP      = 8'h03;
  localparam logic [7:0] CMD_OPEN_SHUTTER    = 8'h04;
  localparam logic [7:0] CMD_CLOSE_SHUTTER   = 8'h05;
  localparam logic [7:0] CMD_TOGGLE_READ_CCD = 8'h06;

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;

  state_t        state, state_nxt;
  logic [7:0]    opcode, opcode_nxt;
  logic [7:0]    arg1, arg1_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          timed_out;

  logic          reg_wr_nxt, adconf_start_nxt, mcp_toggle_nxt;
  logic          shutter_open_nxt, shutter_close_nxt, ccd_toggle_nxt, err_nxt;
  logic [1:0]    reg_addr_nxt, err_code_nxt;
  logic [7:0]    reg_data_nxt;
  logic [15:0]   adconf_word_nxt;

  // A byte landing on the last counted cycle wins over the timeout.
  assign timed_out = (cnt == CNT_LAST) && !rx_valid;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt         = state;
    opcode_nxt        = opcode;
    arg1_nxt          = arg1;
    reg_wr_nxt        = 1'b0;
    adconf_start_nxt  = 1'b0;
    mcp_toggle_nxt    = 1'b0;
    shutter_open_nxt  = 1'b0;
    shutter_close_nxt = 1'b0;
    ccd_toggle_nxt    = 1'b0;
    err_nxt           = 1'b0;
    err_code_nxt      = err_code;
    reg_addr_nxt      = reg_addr;
    reg_data_nxt      = reg_data;
    adconf_word_nxt   = adconf_word;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_SET_REGISTER, CMD_RW_ADCONF: begin
              opcode_nxt = rx_data;
              state_nxt  = ARG1;
            end
            CMD_TOGGLE_MCP:      mcp_toggle_nxt    = 1'b1;
            CMD_OPEN_SHUTTER:    shutter_open_nxt  = 1'b1;
            CMD_CLOSE_SHUTTER:   shutter_close_nxt = 1'b1;
            CMD_TOGGLE_READ_CCD: ccd_toggle_nxt    = 1'b1;
            default: begin
              err_nxt      = 1'b1;
              err_code_nxt = 2'd1;
            end
          endcase
        end
      end
      ARG1: begin
        if (rx_valid) begin
          arg1_nxt  = rx_data;
          state_nxt = ARG2;
        end else if (timed_out) begin
          state_nxt    = IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = 2'd2;
        end
      end
      ARG2: begin
        if (rx_valid) begin
          state_nxt = IDLE;
          if (opcode == CMD_SET_REGISTER) begin
            reg_wr_nxt   = 1'b1;
            reg_addr_nxt = arg1[1:0];
            reg_data_nxt = rx_data;
          end else if (!adconf_busy) begin
            adconf_start_nxt = 1'b1;
            adconf_word_nxt  = {arg1, rx_data};
          end else begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'd3;
          end
        end else if (timed_out) begin
          state_nxt    = IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = 2'd2;
        end
      end
      default: state_nxt = IDLE;
    endcase

    cnt_nxt = (state_nxt == IDLE || rx_valid) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      opcode        <= 8'h00;
      arg1          <= 8'h00;
      cnt           <= '0;
      reg_wr        <= 1'b0;
      adconf_start  <= 1'b0;
      mcp_toggle    <= 1'b0;
      shutter_open  <= 1'b0;
      shutter_close <= 1'b0;
      ccd_toggle    <= 1'b0;
      err           <= 1'b0;
      err_code      <= 2'd0;
      reg_addr      <= 2'd0;
      reg_data      <= 8'h00;
      adconf_word   <= 16'h0000;
    end else begin
      state         <= state_nxt;
      opcode        <= opcode_nxt;
      arg1          <= arg1_nxt;
      cnt           <= cnt_nxt;
      reg_wr        <= reg_wr_nxt;
      adconf_start  <= adconf_start_nxt;
      mcp_toggle    <= mcp_toggle_nxt;
      shutter_open  <= shutter_open_nxt;
      shutter_close <= shutter_close_nxt;
      ccd_toggle    <= ccd_toggle_nxt;
      err           <= err_nxt;
      err_code      <= err_code_nxt;
      reg_addr      <= reg_addr_nxt;
      reg_data      <= reg_data_nxt;
      adconf_word   <= adconf_word_nxt;
    end
  end

endmodule

// File: tb/tb_ft_cmd_decoder.sv
// Scoreboard bench for ft_cmd_decoder: a byte-list command model predicts events per clock edge,
// a negedge monitor pops and compares whenever any strobe is seen.
module tb_ft_cmd_decoder;
  localparam int TO = 16;
  localparam int K_REG = 0, K_AD = 1, K_MCP = 2, K_OPEN = 3, K_CLOSE = 4, K_CCD = 5, K_ERR = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        adconf_busy = 1'b0;
  logic        reg_wr, adconf_start, mcp_toggle, shutter_open, shutter_close, ccd_toggle;
  logic        busy, err;
  logic [1:0]  reg_addr, err_code;
  logic [7:0]  reg_data;
  logic [15:0] adconf_word;

  ft_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .adconf_busy(adconf_busy),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
    .adconf_start(adconf_start), .adconf_word(adconf_word),
    .mcp_toggle(mcp_toggle), .shutter_open(shutter_open), .shutter_close(shutter_close),
    .ccd_toggle(ccd_toggle), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [15:0] word;
    logic [1:0]  code;
  } ev_t;

  ev_t  sb[$];
  bit   exp_busy[int];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   started = 1'b0;

  // Reference model state: bytes of the command collected so far plus the held outputs.
  logic [7:0]  pend[$];
  int          last_byte = 0;
  logic [1:0]  m_addr = 2'd0, m_code = 2'd0;
  logic [7:0]  m_data = 8'h00;
  logic [15:0] m_word = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int e, input int kind);
    ev_t x;
    x.cyc = e; x.kind = kind; x.addr = m_addr; x.data = m_data; x.word = m_word; x.code = m_code;
    sb.push_back(x);
  endtask

  task automatic step(input int e, input bit r, input bit v, input logic [7:0] d, input bit ab);
    logic [7:0] op, a1;
    if (r) begin
      pend.delete();
      m_addr = 2'd0; m_data = 8'h00; m_word = 16'h0000; m_code = 2'd0;
    end else if (v) begin
      if (pend.size() == 0) begin
        case (d)
          8'h01, 8'h02: pend.push_back(d);
          8'h03: push_ev(e, K_MCP);
          8'h04: push_ev(e, K_OPEN);
          8'h05: push_ev(e, K_CLOSE);
          8'h06: push_ev(e, K_CCD);
          default: begin m_code = 2'd1; push_ev(e, K_ERR); end
        endcase
      end else if (pend.size() == 1) begin
        pend.push_back(d);
      end else begin
        op = pend[0]; a1 = pend[1];
        pend.delete();
        if (op == 8'h01) begin
          m_addr = a1[1:0]; m_data = d; push_ev(e, K_REG);
        end else if (!ab) begin
          m_word = {a1, d}; push_ev(e, K_AD);
        end else begin
          m_code = 2'd3; push_ev(e, K_ERR);
        end
      end
      last_byte = e;
    end else if (pend.size() != 0 && e - last_byte == TO) begin
      pend.delete();
      m_code = 2'd2;
      push_ev(e, K_ERR);
    end
    exp_busy[e] = (pend.size() != 0);
  endtask

  task automatic drive(input bit r, input bit v, input logic [7:0] d, input bit ab);
    @(negedge clk);
    rst = r; rx_valid = v; rx_data = v ? d : 8'h00; adconf_busy = ab;
    step(cyc + 1, r, v, d, ab);
  endtask

  task automatic send(input logic [7:0] d, input bit ab = 1'b0);
    drive(1'b0, 1'b1, d, ab);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    if (started) begin
      int   n, kind;
      ev_t  x;
      n = int'(reg_wr) + int'(adconf_start) + int'(mcp_toggle) + int'(shutter_open)
        + int'(shutter_close) + int'(ccd_toggle) + int'(err);
      if (exp_busy.exists(cyc)) chk("busy", busy, exp_busy[cyc]);
      if (n > 1) chk("strobe_onehot", n, 1);
      if (n >= 1) begin
        kind = reg_wr ? K_REG : adconf_start ? K_AD : mcp_toggle ? K_MCP : shutter_open ? K_OPEN :
               shutter_close ? K_CLOSE : ccd_toggle ? K_CCD : K_ERR;
        if (sb.size() == 0) begin
          chk("unexpected_strobe_kind", kind, 32'hFFFF);
        end else begin
          x = sb.pop_front();
          chk("event_edge", cyc, x.cyc);
          chk("event_kind", kind, x.kind);
          chk("reg_addr", reg_addr, x.addr);
          chk("reg_data", reg_data, x.data);
          chk("adconf_word", adconf_word, x.word);
          chk("err_code", err_code, x.code);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    started = 1'b1;
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_data", reg_data, 0);
    chk("rst_adconf_word", adconf_word, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {reg_wr, adconf_start, mcp_toggle, shutter_open, shutter_close, ccd_toggle, err}, 0);

    send(8'h01); send(8'h02); send(8'h00); send(8'h06); idle(3);
    send(8'h02); send(8'h80); send(8'hFF, 1'b0); idle(2);
    send(8'h02); send(8'h80); send(8'hFF, 1'b1); idle(2);
    send(8'h04); idle(4); send(8'h05); idle(4); send(8'h03); idle(4);
    send(8'h7E); send(8'h01); send(8'h06); send(8'h06); idle(2);
    send(8'h01); idle(20); send(8'h04); idle(2);
    send(8'h01); idle(TO - 1); send(8'h03); send(8'h55); idle(2);
    send(8'h02); drive(1'b1, 1'b0, 8'h00, 1'b0); send(8'h11); send(8'h22); idle(3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        idle($urandom_range(TO - 2, TO + 2));
      end else if ($urandom_range(0, 199) == 0) begin
        drive(1'b1, 1'b0, 8'h00, 1'b0);
      end else if ($urandom_range(0, 1) == 1) begin
        d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        send(d, 1'($urandom_range(0, 1)));
      end else begin
        idle(1);
      end
    end
    idle(TO + 4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
